// File: rtl/cpu_pkg.sv
// cpu_pkg: shared ALU codes, opcode/funct7 constants and the decoded-control record
package cpu_pkg;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SLL = 3'b001;
  localparam logic [2:0] ALU_MUL = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SRA = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b111;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  typedef struct packed {
    logic [2:0] alu;
    logic       use_imm;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       illegal;
  } ctrl_t;
  localparam ctrl_t CTRL_NOP = '{alu: ALU_ADD, use_imm: 1'b0, regwrite: 1'b0, memread: 1'b0, memwrite: 1'b0, illegal: 1'b0};
  localparam ctrl_t CTRL_ILL = '{alu: ALU_ADD, use_imm: 1'b0, regwrite: 1'b0, memread: 1'b0, memwrite: 1'b0, illegal: 1'b1};
  function automatic ctrl_t mk_ctrl(input logic [2:0] a, input logic imm, input logic rw, input logic mr, input logic mw);
    return '{alu: a, use_imm: imm, regwrite: rw, memread: mr, memwrite: mw, illegal: 1'b0};
  endfunction
endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: opcode/funct3/funct7 to ALU code and datapath controls
//   opcode_i, funct3_i, funct7_i : instruction fields from ID
//   ctrl_o                       : ALU code, use_imm, regwrite, memread, memwrite, illegal
module alu_ctrl_decode
  import cpu_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output ctrl_t      ctrl_o
);
  logic r_base_ok;
  // base R-type funct3 values coincide with their ALU codes
  assign r_base_ok = funct7_i == F7_BASE && funct3_i inside {3'b000, 3'b001, 3'b100, 3'b111};
  always_comb begin
    ctrl_o = CTRL_ILL;
    case (opcode_i)
      OP_R:      ctrl_o = r_base_ok ? mk_ctrl(funct3_i, 1'b0, 1'b1, 1'b0, 1'b0) :
                          (funct7_i == F7_ALT && funct3_i == 3'b000) ? mk_ctrl(ALU_SUB, 1'b0, 1'b1, 1'b0, 1'b0) :
                          (funct7_i == F7_MULDIV && funct3_i == 3'b000) ? mk_ctrl(ALU_MUL, 1'b0, 1'b1, 1'b0, 1'b0) :
                          CTRL_ILL;
      OP_I:      ctrl_o = funct3_i == 3'b000 ? mk_ctrl(ALU_ADD, 1'b1, 1'b1, 1'b0, 1'b0) :
                          (funct3_i == 3'b101 && funct7_i == F7_ALT) ? mk_ctrl(ALU_SRA, 1'b1, 1'b1, 1'b0, 1'b0) :
                          CTRL_ILL;
      OP_LOAD:   ctrl_o = mk_ctrl(ALU_ADD, 1'b1, 1'b1, 1'b1, 1'b0);
      OP_STORE:  ctrl_o = mk_ctrl(ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b1);
      OP_BRANCH: ctrl_o = mk_ctrl(ALU_SUB, 1'b0, 1'b0, 1'b0, 1'b0);
      default:   ctrl_o = CTRL_ILL;
    endcase
  end
endmodule

// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX register with ALU control decode and EX operand forwarding
//   clk_i, rst_i              : clock, synchronous active-high reset
//   stall_i, flush_i          : hold EX / load a bubble (flush wins)
//   valid_i, instr_i, *_data_i, imm_i : ID-stage instruction and operands
//   exmem_*, memwb_*          : forwarding sources from later stages
//   valid_o .. illegal_o      : EX-cycle operands and controls for the ALU/MEM
module ex_operand_stage
  import cpu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RAW  = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            valid_i,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic            exmem_regwrite_i,
  input  logic [RAW-1:0]  exmem_rd_i,
  input  logic [XLEN-1:0] exmem_data_i,
  input  logic            memwb_regwrite_i,
  input  logic [RAW-1:0]  memwb_rd_i,
  input  logic [XLEN-1:0] memwb_data_i,
  output logic            valid_o,
  output logic [XLEN-1:0] data1_o,
  output logic [XLEN-1:0] data2_o,
  output logic [2:0]      ALUCtrl_o,
  output logic [RAW-1:0]  rd_o,
  output logic            regwrite_o,
  output logic            memread_o,
  output logic            memwrite_o,
  output logic [XLEN-1:0] store_data_o,
  output logic            illegal_o
);
  ctrl_t           dec, ctrl_q, ctrl_d;
  logic            valid_q, valid_d;
  logic [RAW-1:0]  rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d, rd_id, rs1_id, rs2_id;
  logic [XLEN-1:0] v1_q, v1_d, v2_q, v2_d, imm_q, imm_d, fwd1, fwd2;

  function automatic logic hit(input logic we, input logic [RAW-1:0] wr, input logic [RAW-1:0] r);
    return we && wr != '0 && wr == r;
  endfunction

  assign rd_id  = instr_i[7 +: RAW];
  assign rs1_id = instr_i[15 +: RAW];
  assign rs2_id = instr_i[20 +: RAW];

  alu_ctrl_decode u_dec (
    .opcode_i (instr_i[6:0]),
    .funct3_i (instr_i[14:12]),
    .funct7_i (instr_i[31:25]),
    .ctrl_o   (dec)
  );

  assign fwd1 = hit(exmem_regwrite_i, exmem_rd_i, rs1_q) ? exmem_data_i :
                hit(memwb_regwrite_i, memwb_rd_i, rs1_q) ? memwb_data_i : v1_q;
  assign fwd2 = hit(exmem_regwrite_i, exmem_rd_i, rs2_q) ? exmem_data_i :
                hit(memwb_regwrite_i, memwb_rd_i, rs2_q) ? memwb_data_i : v2_q;

  // a stall keeps control but refreshes operand values so retiring results are not lost
  always_comb begin
    {valid_d, ctrl_d, rd_d, rs1_d, rs2_d, imm_d} = {valid_q, ctrl_q, rd_q, rs1_q, rs2_q, imm_q};
    v1_d = fwd1;
    v2_d = fwd2;
    if (flush_i || (!stall_i && !valid_i)) begin
      {valid_d, ctrl_d, rd_d, rs1_d, rs2_d, imm_d, v1_d, v2_d} = '0;
    end else if (!stall_i) begin
      valid_d         = 1'b1;
      ctrl_d          = dec;
      ctrl_d.regwrite = dec.regwrite && rd_id != '0;
      rd_d            = rd_id;
      rs1_d           = rs1_id;
      rs2_d           = rs2_id;
      imm_d           = imm_i;
      v1_d            = hit(memwb_regwrite_i, memwb_rd_i, rs1_id) ? memwb_data_i : rs1_data_i;
      v2_d            = hit(memwb_regwrite_i, memwb_rd_i, rs2_id) ? memwb_data_i : rs2_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      {valid_q, ctrl_q, rd_q, rs1_q, rs2_q, imm_q, v1_q, v2_q} <= '0;
    end else begin
      {valid_q, ctrl_q, rd_q, rs1_q, rs2_q, imm_q, v1_q, v2_q} <= {valid_d, ctrl_d, rd_d, rs1_d, rs2_d, imm_d, v1_d, v2_d};
    end
  end

  assign valid_o      = valid_q;
  assign data1_o      = fwd1;
  assign data2_o      = ctrl_q.use_imm ? imm_q : fwd2;
  assign store_data_o = fwd2;
  assign ALUCtrl_o    = ctrl_q.alu;
  assign rd_o         = rd_q;
  assign regwrite_o   = ctrl_q.regwrite;
  assign memread_o    = ctrl_q.memread;
  assign memwrite_o   = ctrl_q.memwrite;
  assign illegal_o    = ctrl_q.illegal;
endmodule

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage: directed plan scenarios plus randomized run against a reference model
module tb_ex_operand_stage;
  logic        clk = 1'b0;
  logic        rst_i, stall_i, flush_i, valid_i;
  logic [31:0] instr_i, rs1_data_i, rs2_data_i, imm_i, exmem_data_i, memwb_data_i;
  logic        exmem_regwrite_i, memwb_regwrite_i;
  logic [4:0]  exmem_rd_i, memwb_rd_i;
  logic        valid_o, regwrite_o, memread_o, memwrite_o, illegal_o;
  logic [31:0] data1_o, data2_o, store_data_o;
  logic [2:0]  ALUCtrl_o;
  logic [4:0]  rd_o;
  int          errors = 0;
  int          checks = 0;

  ex_operand_stage dut (
    .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
    .instr_i(instr_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i),
    .exmem_regwrite_i(exmem_regwrite_i), .exmem_rd_i(exmem_rd_i), .exmem_data_i(exmem_data_i),
    .memwb_regwrite_i(memwb_regwrite_i), .memwb_rd_i(memwb_rd_i), .memwb_data_i(memwb_data_i),
    .valid_o(valid_o), .data1_o(data1_o), .data2_o(data2_o), .ALUCtrl_o(ALUCtrl_o), .rd_o(rd_o),
    .regwrite_o(regwrite_o), .memread_o(memread_o), .memwrite_o(memwrite_o),
    .store_data_o(store_data_o), .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  // instruction table: {illegal, alu[2:0], use_imm, regwrite, memread, memwrite}
  function automatic logic [7:0] ref_dec(input logic [31:0] i);
    casez ({i[31:25], i[14:12], i[6:0]})
      17'b0000000_000_0110011: return 8'b0_000_0100;
      17'b0000000_001_0110011: return 8'b0_001_0100;
      17'b0000000_100_0110011: return 8'b0_100_0100;
      17'b0000000_111_0110011: return 8'b0_111_0100;
      17'b0100000_000_0110011: return 8'b0_110_0100;
      17'b0000001_000_0110011: return 8'b0_010_0100;
      17'b???????_000_0010011: return 8'b0_000_1100;
      17'b0100000_101_0010011: return 8'b0_101_1100;
      17'b???????_???_0000011: return 8'b0_000_1110;
      17'b???????_???_0100011: return 8'b0_000_1001;
      17'b???????_???_1100011: return 8'b0_110_0000;
      default:                 return 8'b1_000_0000;
    endcase
  endfunction

  function automatic logic [31:0] ref_fwd(input logic [4:0] r, input logic [31:0] v);
    if (exmem_regwrite_i && exmem_rd_i != 0 && exmem_rd_i == r) return exmem_data_i;
    if (memwb_regwrite_i && memwb_rd_i != 0 && memwb_rd_i == r) return memwb_data_i;
    return v;
  endfunction

  logic        m_valid;
  logic [7:0]  m_ctl;
  logic [4:0]  m_rd, m_rs1, m_rs2;
  logic [31:0] m_v1, m_v2, m_imm;

  always @(posedge clk) begin
    if (rst_i || flush_i || (!stall_i && !valid_i)) begin
      m_valid = 0; m_ctl = 0; m_rd = 0; m_rs1 = 0; m_rs2 = 0; m_v1 = 0; m_v2 = 0; m_imm = 0;
    end else if (stall_i) begin
      m_v1 = ref_fwd(m_rs1, m_v1);
      m_v2 = ref_fwd(m_rs2, m_v2);
    end else begin
      m_valid = 1;
      m_ctl   = ref_dec(instr_i);
      if (instr_i[11:7] == 0) m_ctl[2] = 1'b0;
      m_rd  = instr_i[11:7];
      m_rs1 = instr_i[19:15];
      m_rs2 = instr_i[24:20];
      m_imm = imm_i;
      m_v1  = (memwb_regwrite_i && memwb_rd_i != 0 && memwb_rd_i == m_rs1) ? memwb_data_i : rs1_data_i;
      m_v2  = (memwb_regwrite_i && memwb_rd_i != 0 && memwb_rd_i == m_rs2) ? memwb_data_i : rs2_data_i;
    end
  end

  initial begin
    logic [4:0] a, b, d;
    {stall_i, flush_i, valid_i, instr_i, rs1_data_i, rs2_data_i, imm_i} = '0;
    {exmem_regwrite_i, exmem_rd_i, exmem_data_i, memwb_regwrite_i, memwb_rd_i, memwb_data_i} = '0;
    rst_i = 1;
    @(negedge clk); rst_i = 0; #1;
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_regwrite", 32'(regwrite_o), 0);
    chk("rst_alu", 32'(ALUCtrl_o), 0);
    chk("rst_data1", data1_o, 0);
    chk("rst_store", store_data_o, 0);
    valid_i = 1; rs1_data_i = 10; rs2_data_i = 3;
    instr_i = enc(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011);
    @(negedge clk); #1;
    chk("sub_alu", 32'(ALUCtrl_o), 32'b110);
    chk("sub_d1", data1_o, 10);
    chk("sub_d2", data2_o, 3);
    chk("sub_rd", 32'(rd_o), 3);
    chk("sub_rw", 32'(regwrite_o), 1);
    instr_i = enc(7'b0000001, 5'd2, 5'd1, 3'b000, 5'd4, 7'b0110011);
    @(negedge clk); #1;
    chk("mul_alu", 32'(ALUCtrl_o), 32'b010);
    instr_i = enc(7'b0100000, 5'd4, 5'd1, 3'b101, 5'd4, 7'b0010011); imm_i = 4;
    @(negedge clk); #1;
    chk("srai_alu", 32'(ALUCtrl_o), 32'b101);
    chk("srai_d2", data2_o, 4);
    instr_i = enc(7'b1111111, 5'd2, 5'd1, 3'b000, 5'd4, 7'b0110011);
    @(negedge clk); #1;
    chk("ill_flag", 32'(illegal_o), 1);
    chk("ill_rw", 32'(regwrite_o), 0);
    chk("ill_valid", 32'(valid_o), 1);
    instr_i = enc(7'b0000000, 5'd6, 5'd5, 3'b000, 5'd5, 7'b0110011); rs1_data_i = 32'h55;
    @(negedge clk);
    valid_i = 0;
    exmem_regwrite_i = 1; exmem_rd_i = 5; exmem_data_i = 32'h11;
    memwb_regwrite_i = 1; memwb_rd_i = 5; memwb_data_i = 32'h22;
    #1 chk("fwd_exmem", data1_o, 32'h11);
    exmem_regwrite_i = 0;
    #1 chk("fwd_memwb", data1_o, 32'h22);
    exmem_regwrite_i = 1; exmem_rd_i = 0; memwb_rd_i = 0;
    #1 chk("fwd_x0", data1_o, 32'h55);
    stall_i = 1; exmem_regwrite_i = 0; memwb_regwrite_i = 1; memwb_rd_i = 5; memwb_data_i = 32'h99;
    @(negedge clk);
    memwb_regwrite_i = 0; exmem_regwrite_i = 1; exmem_rd_i = 7; #1;
    chk("stall_alu", 32'(ALUCtrl_o), 0);
    chk("stall_rd", 32'(rd_o), 5);
    chk("stall_valid", 32'(valid_o), 1);
    @(negedge clk);
    stall_i = 0; exmem_regwrite_i = 0; #1;
    chk("stall_d1", data1_o, 32'h99);
    chk("stall_rw", 32'(regwrite_o), 1);
    valid_i = 1; instr_i = {7'b0, 5'd2, 5'd1, 3'b010, 5'd8, 7'b0100011};
    rs1_data_i = 32'h100; rs2_data_i = 32'hAB; imm_i = 8;
    @(negedge clk);
    exmem_regwrite_i = 1; exmem_rd_i = 2; exmem_data_i = 32'hCD; #1;
    chk("sw_d1", data1_o, 32'h100);
    chk("sw_d2", data2_o, 8);
    chk("sw_store", store_data_o, 32'hCD);
    chk("sw_mw", 32'(memwrite_o), 1);
    chk("sw_rw", 32'(regwrite_o), 0);
    stall_i = 1; flush_i = 1;
    @(negedge clk); #1;
    chk("flush_valid", 32'(valid_o), 0);
    chk("flush_mw", 32'(memwrite_o), 0);
    chk("flush_alu", 32'(ALUCtrl_o), 0);
    stall_i = 0; flush_i = 0;
    @(negedge clk);
    for (int n = 0; n < 1500; n++) begin
      a = 5'($urandom_range(0, 7)); b = 5'($urandom_range(0, 7)); d = 5'($urandom_range(0, 7));
      case ($urandom_range(0, 11))
        0: instr_i = enc(7'b0000000, b, a, 3'b000, d, 7'b0110011);
        1: instr_i = enc(7'b0000000, b, a, 3'b001, d, 7'b0110011);
        2: instr_i = enc(7'b0000000, b, a, 3'b100, d, 7'b0110011);
        3: instr_i = enc(7'b0000000, b, a, 3'($urandom_range(0, 7)), d, 7'b0110011);
        4: instr_i = enc(7'b0100000, b, a, 3'b000, d, 7'b0110011);
        5: instr_i = enc(7'b0000001, b, a, 3'b000, d, 7'b0110011);
        6: instr_i = enc(7'($urandom), b, a, 3'b000, d, 7'b0010011);
        7: instr_i = enc(7'b0100000, b, a, 3'b101, d, 7'b0010011);
        8: instr_i = enc(7'($urandom), b, a, 3'b010, d, 7'b0000011);
        9: instr_i = enc(7'($urandom), b, a, 3'b010, d, 7'b0100011);
        10: instr_i = enc(7'($urandom), b, a, 3'b000, d, 7'b1100011);
        default: instr_i = $urandom;
      endcase
      rst_i = $urandom_range(0, 40) == 0;
      stall_i = $urandom_range(0, 4) == 0;
      flush_i = $urandom_range(0, 9) == 0;
      valid_i = $urandom_range(0, 7) != 0;
      rs1_data_i = $urandom; rs2_data_i = $urandom; imm_i = $urandom;
      exmem_regwrite_i = 1'($urandom); exmem_rd_i = 5'($urandom_range(0, 7)); exmem_data_i = $urandom;
      memwb_regwrite_i = 1'($urandom); memwb_rd_i = 5'($urandom_range(0, 7)); memwb_data_i = $urandom;
      #1;
      chk("r_valid", 32'(valid_o), 32'(m_valid));
      chk("r_alu", 32'(ALUCtrl_o), 32'(m_ctl[6:4]));
      chk("r_rw", 32'(regwrite_o), 32'(m_ctl[2]));
      chk("r_mr", 32'(memread_o), 32'(m_ctl[1]));
      chk("r_mw", 32'(memwrite_o), 32'(m_ctl[0]));
      chk("r_ill", 32'(illegal_o), 32'(m_ctl[7]));
      if (m_valid) begin
        chk("r_rd", 32'(rd_o), 32'(m_rd));
        chk("r_d1", data1_o, ref_fwd(m_rs1, m_v1));
        chk("r_d2", data2_o, m_ctl[3] ? m_imm : ref_fwd(m_rs2, m_v2));
        chk("r_store", store_data_o, ref_fwd(m_rs2, m_v2));
      end
      @(negedge clk);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
